// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Purpose  : Shared types and action encodings for the pipeline sequencer.
//             pipe_ctrl_state_e : sequencer states
//             pipe_ctrl_t       : the nine enable/clear bits driven to the
//                                 PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERR      = 3'd4
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_clr;
    logic id_ex_clr;
    logic ex_mem_clr;
    logic mem_wb_clr;
  } pipe_ctrl_t;

  // Bit order: pc, if_id, id_ex, ex_mem, mem_wb enables | if_id .. mem_wb clears
  localparam pipe_ctrl_t ACT_NORMAL     = 9'b11111_0000;
  // Everything holds; WB gets a bubble so the held MEM/WB entry is not retired twice
  localparam pipe_ctrl_t ACT_FREEZE     = 9'b00001_0001;
  localparam pipe_ctrl_t ACT_REDIRECT   = 9'b11111_1100;
  // PC and IF/ID hold, a bubble enters EX, older instructions keep moving
  localparam pipe_ctrl_t ACT_LOADSTALL  = 9'b00111_0100;
  // Draining: fetch stops and IF/ID loads bubbles so the pipe empties
  localparam pipe_ctrl_t ACT_DRAIN_IDLE = 9'b01111_1000;
  localparam pipe_ctrl_t ACT_IDLE       = 9'b00000_0000;
  localparam pipe_ctrl_t ACT_RESET      = 9'b00000_1111;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Bundle of hazard inputs and pipeline control outputs.
//             master : pipeline side (drives hazard info, receives controls)
//             slave  : sequencer side
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_rd_wren_i;
  logic             ex_is_load_i;
  logic             ex_br_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             halt_req_i;
  logic             pc_en_o;
  logic             if_id_en_o;
  logic             id_ex_en_o;
  logic             ex_mem_en_o;
  logic             mem_wb_en_o;
  logic             if_id_clr_o;
  logic             id_ex_clr_o;
  logic             ex_mem_clr_o;
  logic             mem_wb_clr_o;
  logic             halt_ack_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           ex_rd_addr_i, ex_rd_wren_i, ex_is_load_i, ex_br_taken_i,
           mem_req_i, mem_ready_i, halt_req_i,
    input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_clr_o, id_ex_clr_o, ex_mem_clr_o, mem_wb_clr_o,
           halt_ack_o, err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           ex_rd_addr_i, ex_rd_wren_i, ex_is_load_i, ex_br_taken_i,
           mem_req_i, mem_ready_i, halt_req_i,
    output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_clr_o, id_ex_clr_o, ex_mem_clr_o, mem_wb_clr_o,
           halt_ack_o, err_o, stall_cnt_o, flush_cnt_o
  );
endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Purpose  : Flags a load in EX whose destination is read by the ID-stage
//             instruction. x0 never creates a dependency.
//  Ports    : rs1/rs2 addr+used (ID), rd addr/wren/is_load (EX) -> load_use
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect (
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd_addr,
  input  logic       rd_wren,
  input  logic       is_load,
  output logic       load_use
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = rs1_used && (rs1_addr == rd_addr);
  assign w_rs2_hit = rs2_used && (rs2_addr == rd_addr);
  assign load_use  = is_load && rd_wren && (rd_addr != 5'd0) && (w_rs1_hit || w_rs2_hit);
endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : 5-stage pipeline sequencer: load-use stalls, redirect flushes,
//             LSU wait freezes, debug halt/drain handshake, LSU timeout error
//             and saturating stall/flush counters.
//  Ports    : clk_i, rst_i (sync, active-high), bus (pipe_hazard_ctrl_if.slave)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int DRAIN_DEPTH = 4,
  parameter int CNT_W       = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int DRAIN_W = (DRAIN_DEPTH > 2) ? $clog2(DRAIN_DEPTH) : 1;

  localparam logic [2:0] ST_RUN      = RUN;
  localparam logic [2:0] ST_MEM_WAIT = MEM_WAIT;
  localparam logic [2:0] ST_DRAIN    = DRAIN;
  localparam logic [2:0] ST_HALTED   = HALTED;
  localparam logic [2:0] ST_ERR      = ERR;

  logic [2:0]         r_state, w_nxt_state;
  logic [2:0]         r_ret, w_nxt_ret;
  logic [WAIT_W-1:0]  r_wait_cnt, w_nxt_wait;
  logic [DRAIN_W-1:0] r_drain_cnt, w_nxt_drain;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;

  logic       w_f, w_lu, w_act_run, w_act_drain;
  logic       w_redirect, w_stall, w_ack, w_err;
  pipe_ctrl_t w_ctrl, w_out;

  assign w_f = bus.mem_req_i && !bus.mem_ready_i;

  load_use_detect u_lu (
    .rs1_addr (bus.id_rs1_addr_i),
    .rs2_addr (bus.id_rs2_addr_i),
    .rs1_used (bus.id_rs1_used_i),
    .rs2_used (bus.id_rs2_used_i),
    .rd_addr  (bus.ex_rd_addr_i),
    .rd_wren  (bus.ex_rd_wren_i),
    .is_load  (bus.ex_is_load_i),
    .load_use (w_lu)
  );

  always_comb begin
    w_ctrl      = ACT_IDLE;
    w_nxt_state = r_state;
    w_nxt_ret   = r_ret;
    w_nxt_wait  = r_wait_cnt;
    w_nxt_drain = r_drain_cnt;
    w_redirect  = 1'b0;
    w_ack       = 1'b0;
    w_err       = 1'b0;

    // The release cycle of an LSU wait behaves exactly like the state it returns to
    w_act_run   = (r_state == ST_RUN) ||
                  ((r_state == ST_MEM_WAIT) && !w_f && (r_ret == ST_RUN));
    w_act_drain = (r_state == ST_DRAIN) ||
                  ((r_state == ST_MEM_WAIT) && !w_f && (r_ret == ST_DRAIN));

    case (r_state)
      ST_ERR:    w_err = 1'b1;
      ST_HALTED: begin
        w_ack = 1'b1;
        if (!bus.halt_req_i) w_nxt_state = ST_RUN;
      end
      ST_MEM_WAIT: begin
        if (w_f) begin
          w_ctrl     = ACT_FREEZE;
          w_nxt_wait = r_wait_cnt + 1'b1;
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) w_nxt_state = ST_ERR;
        end else begin
          w_nxt_wait = '0;
        end
      end
      ST_RUN, ST_DRAIN: ;
      default: w_nxt_state = ST_RUN;
    endcase

    if (w_act_run || w_act_drain) begin
      if (w_f) begin
        w_ctrl      = ACT_FREEZE;
        w_nxt_state = ST_MEM_WAIT;
        w_nxt_ret   = w_act_drain ? ST_DRAIN : ST_RUN;
        w_nxt_wait  = WAIT_W'(1);
      end else begin
        if (bus.ex_br_taken_i) begin
          w_ctrl     = ACT_REDIRECT;
          w_redirect = 1'b1;
        end else if (w_lu) begin
          w_ctrl = ACT_LOADSTALL;
        end else begin
          w_ctrl = w_act_drain ? ACT_DRAIN_IDLE : ACT_NORMAL;
        end

        if (w_act_run) begin
          if (bus.halt_req_i) begin
            w_nxt_state = ST_DRAIN;
            w_nxt_drain = '0;
          end else begin
            w_nxt_state = ST_RUN;
          end
        end else if (!bus.halt_req_i) begin
          w_nxt_state = ST_RUN;
        end else if (!w_lu) begin
          // A load-use cycle did not advance the bubble front, so it is not counted
          if (r_drain_cnt == DRAIN_W'(DRAIN_DEPTH - 1)) begin
            w_nxt_state = ST_HALTED;
          end else begin
            w_nxt_state = ST_DRAIN;
            w_nxt_drain = r_drain_cnt + 1'b1;
          end
        end else begin
          w_nxt_state = ST_DRAIN;
        end
      end
    end

    // Stall accounting follows the state register: RUN and MEM_WAIT cycles only
    w_stall = !w_ctrl.pc_en && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));

    w_out = rst_i ? ACT_RESET : w_ctrl;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_ret       <= ST_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_ret       <= w_nxt_ret;
      r_wait_cnt  <= w_nxt_wait;
      r_drain_cnt <= w_nxt_drain;
      if (w_stall && !(&r_stall_cnt))    r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_en_o      = w_out.pc_en;
  assign bus.if_id_en_o   = w_out.if_id_en;
  assign bus.id_ex_en_o   = w_out.id_ex_en;
  assign bus.ex_mem_en_o  = w_out.ex_mem_en;
  assign bus.mem_wb_en_o  = w_out.mem_wb_en;
  assign bus.if_id_clr_o  = w_out.if_id_clr;
  assign bus.id_ex_clr_o  = w_out.id_ex_clr;
  assign bus.ex_mem_clr_o = w_out.ex_mem_clr;
  assign bus.mem_wb_clr_o = w_out.mem_wb_clr;
  assign bus.halt_ack_o   = w_ack && !rst_i;
  assign bus.err_o        = w_err && !rst_i;
  assign bus.stall_cnt_o  = r_stall_cnt;
  assign bus.flush_cnt_o  = r_flush_cnt;
endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//             with literal expectations, then randomized traffic against a
//             behavioural model of the sequencing rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;
  localparam int DRAIN_DEPTH = 4;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DRAIN_DEPTH (DRAIN_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: plain flags and counts
  bit     m_err, m_halted, m_drain, m_frozen;
  int     m_wait, m_done;
  longint m_stall, m_flush;
  longint cnt_max = (longint'(1) << CNT_W) - 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit u1, input bit u2, input bit ld, input bit wr, input bit br,
                       input bit mreq, input bit mrdy, input bit halt);
    bus.id_rs1_addr_i = rs1;  bus.id_rs2_addr_i = rs2;
    bus.id_rs1_used_i = u1;   bus.id_rs2_used_i = u2;
    bus.ex_rd_addr_i  = rd;   bus.ex_rd_wren_i  = wr;
    bus.ex_is_load_i  = ld;   bus.ex_br_taken_i = br;
    bus.mem_req_i     = mreq; bus.mem_ready_i   = mrdy;
    bus.halt_req_i    = halt;
  endtask

  task automatic idle(input bit halt);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, halt);
  endtask

  // Compare all outputs against the model, then advance the model over the edge.
  // Called after inputs are set at the falling edge; returns before the rising edge.
  task automatic step();
    bit f, lu, br, halt, redirect, stall, e_ack, e_err;
    logic [8:0] e;
    logic [8:0] got;
    #2;
    f    = bus.mem_req_i && !bus.mem_ready_i;
    br   = bus.ex_br_taken_i;
    halt = bus.halt_req_i;
    lu   = bus.ex_is_load_i && bus.ex_rd_wren_i && (bus.ex_rd_addr_i != 0) &&
           ((bus.id_rs1_used_i && bus.id_rs1_addr_i == bus.ex_rd_addr_i) ||
            (bus.id_rs2_used_i && bus.id_rs2_addr_i == bus.ex_rd_addr_i));
    redirect = 0; e_ack = 0; e_err = 0;
    if (rst)           e = 9'b00000_1111;
    else if (m_err)    begin e = 9'b0; e_err = 1; end
    else if (m_halted) begin e = 9'b0; e_ack = 1; end
    else if (f)        e = 9'b00001_0001;
    else if (br)       begin e = 9'b11111_1100; redirect = 1; end
    else if (lu)       e = 9'b00111_0100;
    else if (m_drain)  e = 9'b01111_1000;
    else               e = 9'b11111_0000;

    got = {bus.pc_en_o, bus.if_id_en_o, bus.id_ex_en_o, bus.ex_mem_en_o, bus.mem_wb_en_o,
           bus.if_id_clr_o, bus.id_ex_clr_o, bus.ex_mem_clr_o, bus.mem_wb_clr_o};
    chk("ctrl_bits", 64'(got), 64'(e));
    chk("halt_ack", 64'(bus.halt_ack_o), 64'(e_ack));
    chk("err", 64'(bus.err_o), 64'(e_err));
    chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_stall));
    chk("flush_cnt", 64'(bus.flush_cnt_o), 64'(m_flush));

    // A cycle is a stall if fetch is held outside the drain/halt/error phases;
    // frozen cycles after the first are LSU-wait cycles and always count.
    stall = !m_err && !m_halted && (m_frozen || !m_drain) && !e[8];

    if (rst) begin
      m_err = 0; m_halted = 0; m_drain = 0; m_frozen = 0;
      m_wait = 0; m_done = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (stall && m_stall < cnt_max)    m_stall++;
      if (redirect && m_flush < cnt_max) m_flush++;
      if (m_err) begin
      end else if (m_halted) begin
        if (!halt) begin m_halted = 0; m_drain = 0; end
      end else if (f) begin
        m_frozen = 1;
        m_wait++;
        if (m_wait == MEM_TIMEOUT) m_err = 1;
      end else begin
        m_frozen = 0;
        m_wait   = 0;
        if (!m_drain) begin
          if (halt) begin m_drain = 1; m_done = 0; end
        end else if (!halt) begin
          m_drain = 0;
        end else if (!lu) begin
          m_done++;
          if (m_done == DRAIN_DEPTH) begin m_halted = 1; m_drain = 0; end
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle(1'b0);
    rst = 1'b1;

    // Reset values
    cyc(); step();
    chk("rst_ctrl", 64'({bus.pc_en_o, bus.id_ex_en_o, bus.if_id_clr_o, bus.mem_wb_clr_o}), 64'h3);
    cyc(); step();
    chk("rst_cnt", 64'(bus.stall_cnt_o), 64'd0);
    rst = 1'b0;

    // Load-use on x5 -> one loadstall
    cyc(); drive(5'd5, 5'd9, 5'd5, 1, 0, 1, 1, 0, 0, 1, 0); step();
    chk("lu_pc_en", 64'(bus.pc_en_o), 64'd0);
    chk("lu_id_ex_clr", 64'(bus.id_ex_clr_o), 64'd1);
    cyc(); idle(0); step();
    chk("lu_stall_cnt", 64'(bus.stall_cnt_o), 64'd1);
    // Same with rd = x0 -> no stall
    cyc(); drive(5'd0, 5'd9, 5'd0, 1, 0, 1, 1, 0, 0, 1, 0); step();
    chk("lu_x0_pc_en", 64'(bus.pc_en_o), 64'd1);

    // Taken branch
    cyc(); drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0, 1, 0); step();
    chk("br_if_id_clr", 64'(bus.if_id_clr_o), 64'd1);
    chk("br_pc_en", 64'(bus.pc_en_o), 64'd1);
    cyc(); idle(0); step();
    chk("br_flush_cnt", 64'(bus.flush_cnt_o), 64'd1);

    // Three-cycle LSU wait with a concurrent branch
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1, 0, 0); step();
      chk("frz_mem_wb_clr", 64'(bus.mem_wb_clr_o), 64'd1);
      chk("frz_no_flush", 64'(bus.if_id_clr_o), 64'd0);
    end
    cyc(); drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1, 1, 0); step();
    chk("rel_redirect", 64'(bus.if_id_clr_o), 64'd1);
    cyc(); idle(0); step();
    chk("frz_stall_cnt", 64'(bus.stall_cnt_o), 64'd4);
    chk("frz_flush_cnt", 64'(bus.flush_cnt_o), 64'd2);

    // Halt with no hazards: 4 drain cycles then ack
    cyc(); idle(1); step();
    chk("halt_run_pc_en", 64'(bus.pc_en_o), 64'd1);
    for (int i = 0; i < DRAIN_DEPTH; i++) begin
      cyc(); idle(1); step();
      chk("drain_bits", 64'({bus.pc_en_o, bus.if_id_clr_o, bus.halt_ack_o}), 64'b010);
    end
    cyc(); idle(1); step();
    chk("halt_ack", 64'(bus.halt_ack_o), 64'd1);
    cyc(); idle(0); step();
    chk("ack_hold", 64'(bus.halt_ack_o), 64'd1);
    cyc(); idle(0); step();
    chk("ack_drop_pc_en", 64'({bus.halt_ack_o, bus.pc_en_o}), 64'b01);
    chk("halt_stall_cnt", 64'(bus.stall_cnt_o), 64'd4);

    // Load-use during drain delays halt by one cycle
    cyc(); idle(1); step();
    cyc(); idle(1); step();
    cyc(); drive(5'd7, 5'd9, 5'd7, 1, 0, 1, 1, 0, 0, 1, 1); step();
    for (int i = 0; i < 3; i++) begin cyc(); idle(1); step(); end
    chk("lu_drain_no_ack", 64'(bus.halt_ack_o), 64'd0);
    cyc(); idle(1); step();
    chk("lu_drain_ack", 64'(bus.halt_ack_o), 64'd1);
    cyc(); idle(0); step();
    cyc(); idle(0); step();

    // LSU timeout
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      cyc(); drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 1, 0, 0); step();
    end
    cyc(); step();
    chk("timeout_err", 64'({bus.err_o, bus.pc_en_o, bus.mem_wb_en_o}), 64'b100);
    cyc(); rst = 1'b1; step();
    chk("err_rst_clear", 64'(bus.err_o), 64'd0);
    cyc(); rst = 1'b0; idle(0); step();
    chk("post_rst_run", 64'({bus.pc_en_o, bus.err_o}), 64'b10);
    chk("post_rst_cnt", 64'(bus.stall_cnt_o), 64'd0);

    // Reset in the middle of an LSU wait
    for (int i = 0; i < 2; i++) begin
      cyc(); drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 1, 0, 0); step();
    end
    cyc(); rst = 1'b1; step();
    chk("rst_midwait", 64'({bus.pc_en_o, bus.mem_wb_en_o, bus.if_id_clr_o, bus.ex_mem_clr_o}), 64'b0011);
    cyc(); rst = 1'b0; idle(0); step();
    chk("rst_midwait_run", 64'({bus.pc_en_o, bus.mem_wb_clr_o}), 64'b10);

    // Randomized traffic against the model
    begin
      bit halt_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
        cyc();
        if ($urandom_range(0, 19) == 0) halt_lvl = !halt_lvl;
        rst = ($urandom_range(0, 299) == 0);
        drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), 1'($urandom),
              halt_lvl);
        step();
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
